// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Purpose  : Shared types and helpers for the unified-memory port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

    // Which pipeline stage owns the current memory access.
    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Arbiter sequencing states.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Ceiling log2 of v (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter width able to hold MEM_LATENCY-1, never narrower than one bit.
    function automatic int cnt_width(input int lat);
        return (clog2(lat) < 1) ? 1 : clog2(lat);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_timer
// Purpose  : Load/decrement access counter with a terminal-count flag.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Load on grant, count down while the access is running, park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the IF and MEM stages,
//            with alternating priority under contention and per-stage stalls.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [29:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                 c_CNT_W = cnt_width(MEM_LATENCY);
    localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(MEM_LATENCY - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    owner_t              r_last_owner;
    owner_t              w_grant_owner;
    logic                r_we;
    logic [29:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_grant;
    logic                w_final;
    logic                w_done;

    // Byte-lane bits are not used: the memory is word addressed.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    // Counts the held cycles of the current access.
    mem_access_timer #(
        .CNT_W (c_CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_grant),
        .i_load_val (c_LOAD),
        .i_dec      (r_state == ST_ACCESS),
        .o_done     (w_done)
    );

    // Winner selection: under contention the side not served last wins.
    always_comb begin
        w_grant_owner = OWN_D;
        if (if_req && d_req) begin
            w_grant_owner = (r_last_owner == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req) begin
            w_grant_owner = OWN_IF;
        end
    end

    // Next-state logic and memory/ack outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_final     = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        if_ack      = 1'b0;
        d_ack       = 1'b0;
        if_rdata    = '0;
        d_rdata     = '0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en = 1'b1;
                if (w_done) begin
                    w_final     = 1'b1;
                    w_state_nxt = ST_IDLE;
                    mem_we      = r_we;
                    if (r_owner == OWN_IF) begin
                        if_ack   = 1'b1;
                        if_rdata = mem_rdata;
                    end else begin
                        d_ack   = 1'b1;
                        d_rdata = mem_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture request at grant; remember who was served on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_D;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_owner;
                r_addr  <= (w_grant_owner == OWN_IF) ? if_addr[31:2] : d_addr[31:2];
                r_wdata <= d_wdata;
                r_we    <= d_we && (w_grant_owner == OWN_D);
            end
            if (w_final) begin
                r_last_owner <= r_owner;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench: two arbiters (latency 2 and 3) on shared
//            stimulus, directed vector table, corner sequences and a random
//            phase checked against a cycle-count reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] if_rdata_o  [2];
    logic [31:0] d_rdata_o   [2];
    logic [31:0] mem_wdata_o [2];
    logic [29:0] mem_addr_o  [2];
    logic [1:0]  if_ack_o, d_ack_o, stall_if_o, stall_mem_o, mem_en_o, mem_we_o;

    mem_port_arbiter #(.MEM_LATENCY(2), .DATA_W(32)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[0]), .if_ack(if_ack_o[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_o[0]), .d_ack(d_ack_o[0]),
        .stall_if(stall_if_o[0]), .stall_mem(stall_mem_o[0]),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .DATA_W(32)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[1]), .if_ack(if_ack_o[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_o[1]), .d_ack(d_ack_o[1]),
        .stall_if(stall_if_o[1]), .stall_mem(stall_mem_o[1]),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles left in the current access (0 = idle), plus
    // what was captured at grant and who was served last (1 = data side).
    int          m_rem   [2];
    bit          m_own   [2];
    bit          m_last  [2];
    bit          m_we    [2];
    logic [29:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    bit          m_valid = 1'b0;

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            bit fin, ia, da;
            fin = (m_rem[k] == 1);
            ia  = fin && !m_own[k];
            da  = fin && m_own[k];
            chk("mem_en",    k, mem_en_o[k],    m_rem[k] > 0);
            chk("mem_we",    k, mem_we_o[k],    da && m_we[k]);
            chk("if_ack",    k, if_ack_o[k],    ia);
            chk("d_ack",     k, d_ack_o[k],     da);
            chk("if_rdata",  k, if_rdata_o[k],  ia ? mem_rdata : 32'h0);
            chk("d_rdata",   k, d_rdata_o[k],   da ? mem_rdata : 32'h0);
            chk("stall_if",  k, stall_if_o[k],  if_req && !ia);
            chk("stall_mem", k, stall_mem_o[k], d_req && !da);
            chk("mem_addr",  k, mem_addr_o[k],  m_addr[k]);
            chk("mem_wdata", k, mem_wdata_o[k], m_wdata[k]);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_rem[k] = 0; m_own[k] = 1'b0; m_last[k] = 1'b1;
                m_we[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0;
            end else if (m_rem[k] > 0) begin
                if (m_rem[k] == 1) m_last[k] = m_own[k];
                m_rem[k]--;
            end else if (if_req || d_req) begin
                m_own[k]   = (if_req && d_req) ? !m_last[k] : d_req;
                m_addr[k]  = m_own[k] ? d_addr[31:2] : if_addr[31:2];
                m_wdata[k] = d_wdata;
                m_we[k]    = m_own[k] && d_we;
                m_rem[k]   = lat(k);
            end
        end
        if (reset) m_valid = 1'b1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        if (m_valid) model_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic drive(input bit r, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
        reset = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    // One cycle of directed stimulus with expected latency-2 flags
    // {if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem} and mem_addr.
    typedef struct {
        bit          rst;
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [5:0]  exp;
        logic [29:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit rst, input bit ir, input logic [31:0] ia, input bit dr,
                                input bit dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic [5:0] exp, input logic [29:0] eaddr);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.exp = exp; v.eaddr = eaddr;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        mem_rdata = 32'h0;
        drive(1, 0, 0, 0, 0, 0, 0);

        // Single fetch, latency 2.
        tbl.push_back(mk(0, 1, 32'h0040_0008, 0, 0, 0, 0, 6'b000010, 30'h0));
        tbl.push_back(mk(0, 1, 32'h0040_0008, 0, 0, 0, 0, 6'b001010, 30'h0010_0002));
        tbl.push_back(mk(0, 1, 32'h0040_0008, 0, 0, 0, 0, 6'b101000, 30'h0010_0002));
        tbl.push_back(mk(0, 0, 32'h0040_0008, 0, 0, 0, 0, 6'b000000, 30'h0010_0002));
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 0, 6'b000000, 30'h0010_0002));
        // Sustained contention from reset: IF@2, D@5, IF@8, D@11 (data side stores).
        for (int c = 0; c < 12; c++) begin
            logic [5:0]  e;
            logic [29:0] a;
            case (c % 6)
                0: e = 6'b000011;
                1: e = 6'b001011;
                2: e = 6'b101001;
                3: e = 6'b000011;
                4: e = 6'b001011;
                default: e = 6'b011110;
            endcase
            if (c == 0)                 a = 30'h0;
            else if ((c % 6) inside {1, 2, 3}) a = 30'h0010_0004;
            else                        a = 30'h0400_4002;
            tbl.push_back(mk(0, 1, 32'h0040_0010, 1, 1, 32'h1001_0008, 32'hCAFE_F00D, e, a));
        end
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 6'b000000, 30'h0400_4002));
        // Data request dropped mid-access with a changing address.
        tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h1001_0020, 32'h1234_5678, 6'b000001, 30'h0400_4002));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 32'h2000_0000, 32'h0,         6'b001000, 30'h0400_4008));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 32'h2000_0000, 32'h0,         6'b011000, 30'h0400_4008));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,         32'h0,         6'b000000, 30'h0400_4008));

        // Reset and reset-value checks.
        at_pos();
        at_pos();
        drive(0, 0, 0, 0, 0, 0, 0);
        at_neg();
        for (int k = 0; k < 2; k++) begin
            chk("rst_outputs", k, {mem_en_o[k], mem_we_o[k], if_ack_o[k], d_ack_o[k]}, 4'b0000);
            chk("rst_addr",    k, mem_addr_o[k], 30'h0);
            chk("rst_wdata",   k, mem_wdata_o[k], 32'h0);
            chk("rst_rdata",   k, {if_rdata_o[k], d_rdata_o[k]}, 64'h0);
        end
        at_pos();

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            at_neg();
            chk("tbl_flags", 0, {if_ack_o[0], d_ack_o[0], mem_en_o[0], mem_we_o[0],
                                 stall_if_o[0], stall_mem_o[0]}, tbl[i].exp);
            chk("tbl_addr",  0, mem_addr_o[0], tbl[i].eaddr);
            at_pos();
        end

        // Store on the latency-3 arbiter.
        drive(1, 0, 0, 0, 0, 0, 0);
        at_pos();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, c < 4, 1, 32'h1001_0004, 32'hDEAD_BEEF);
            at_neg();
            chk("st_mem_en", 1, mem_en_o[1], (c >= 1) && (c <= 3));
            chk("st_mem_we", 1, mem_we_o[1], c == 3);
            if (c >= 1) begin
                chk("st_addr",  1, mem_addr_o[1],  30'h0400_4001);
                chk("st_wdata", 1, mem_wdata_o[1], 32'hDEAD_BEEF);
            end
            at_pos();
        end

        // Reset in the middle of a latency-2 fetch.
        drive(1, 0, 0, 0, 0, 0, 0);
        at_pos();
        drive(0, 1, 32'h0040_0100, 0, 0, 0, 0);
        at_neg();
        at_pos();
        reset = 1'b1;
        at_neg();
        chk("mid_en", 0, mem_en_o[0], 1'b1);
        at_pos();
        reset = 1'b0;
        at_neg();
        chk("post_rst_en",  0, mem_en_o[0], 1'b0);
        chk("post_rst_ack", 0, if_ack_o[0], 1'b0);
        at_pos();
        found = -1;
        for (int c = 3; c < 12; c++) begin
            at_neg();
            if (if_ack_o[0] === 1'b1) found = c;
            at_pos();
            if (found >= 0) break;
        end
        chk("reack_cycle", 0, found, 4);
        if_req = 1'b0;
        at_neg();
        at_pos();

        // Random phase.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 50) == 0, ($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                  $urandom % 2, $urandom, $urandom);
            at_neg();
            at_pos();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
